// File: rtl/clk_div_reconfig_ctrl_if.sv
// Request/status and divider-control signals shared between the config logic
// (master) and the reconfiguration controller (slave).
interface clk_div_reconfig_ctrl_if #(
  parameter int N_W = 8
);
  logic           req_valid;
  logic [N_W-1:0] req_n;
  logic           req_ready;
  logic [N_W-1:0] div_n;
  logic           div_rst_n;
  logic           clk_en;
  logic           busy;
  logic           cfg_done;
  logic           cfg_err;

  modport master (
    output req_valid,
    output req_n,
    input  req_ready,
    input  div_n,
    input  div_rst_n,
    input  clk_en,
    input  busy,
    input  cfg_done,
    input  cfg_err
  );

  modport slave (
    input  req_valid,
    input  req_n,
    output req_ready,
    output div_n,
    output div_rst_n,
    output clk_en,
    output busy,
    output cfg_done,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_reconfig_ctrl.sv
// Glitch-free run-time ratio change for the integer clock divider: waits for a
// period boundary, gates the divided clock, resets/reloads the divider, re-enables.
module clk_div_reconfig_ctrl #(
  parameter int N_W       = 8,
  parameter int N_DEFAULT = 5,
  parameter int N_MIN     = 2,
  parameter int GUARD_CYC = 2
) (
  input  logic                    i_clk_in,
  input  logic                    i_rst_n,
  clk_div_reconfig_ctrl_if.slave  bus
);

  localparam int G_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [N_W-1:0] C_N_DEFAULT  = N_W'(N_DEFAULT);
  localparam logic [N_W-1:0] C_N_MIN      = N_W'(N_MIN);
  localparam logic [N_W-1:0] C_ONE        = N_W'(1);
  localparam logic [G_W-1:0] C_GUARD_LAST = G_W'(GUARD_CYC - 1);
  localparam logic [G_W-1:0] C_GUARD_ONE  = G_W'(1);

  typedef enum logic [2:0] {
    S_RELOAD,
    S_SETTLE,
    S_IDLE,
    S_WAIT_EDGE,
    S_GATE
  } state_t;

  state_t         r_state,     w_state_next;
  logic [N_W-1:0] r_div_n,     w_div_n_next;
  logic [N_W-1:0] r_pending,   w_pending_next;
  logic [N_W-1:0] r_phase,     w_phase_next;
  logic [G_W-1:0] r_guard,     w_guard_next;
  logic           r_div_rst_n, w_div_rst_n_next;
  logic           r_clk_en,    w_clk_en_next;
  logic           r_cfg_done,  w_cfg_done_next;
  logic           r_cfg_err,   w_cfg_err_next;
  logic           r_from_req,  w_from_req_next;

  logic [N_W-1:0] w_div_n_m1;
  logic           w_at_boundary;
  logic           w_guard_last;

  assign w_div_n_m1    = r_div_n - C_ONE;
  assign w_at_boundary = (r_phase == w_div_n_m1);
  assign w_guard_last  = (r_guard == C_GUARD_LAST);

  always_ff @(posedge i_clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RELOAD;
      r_div_n     <= C_N_DEFAULT;
      r_pending   <= C_N_DEFAULT;
      r_phase     <= '0;
      r_guard     <= '0;
      r_div_rst_n <= 1'b0;
      r_clk_en    <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_from_req  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_div_n     <= w_div_n_next;
      r_pending   <= w_pending_next;
      r_phase     <= w_phase_next;
      r_guard     <= w_guard_next;
      r_div_rst_n <= w_div_rst_n_next;
      r_clk_en    <= w_clk_en_next;
      r_cfg_done  <= w_cfg_done_next;
      r_cfg_err   <= w_cfg_err_next;
      r_from_req  <= w_from_req_next;
    end
  end

  // Phase mirror tracks the divider's internal counter edge for edge.
  always_comb begin
    w_phase_next = r_phase + C_ONE;
    if (!r_div_rst_n || w_at_boundary) begin
      w_phase_next = '0;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_div_n_next     = r_div_n;
    w_pending_next   = r_pending;
    w_guard_next     = r_guard;
    w_div_rst_n_next = r_div_rst_n;
    w_clk_en_next    = r_clk_en;
    w_cfg_done_next  = 1'b0;
    w_cfg_err_next   = 1'b0;
    w_from_req_next  = r_from_req;

    case (r_state)
      S_RELOAD: begin
        w_div_rst_n_next = 1'b1;
        w_guard_next     = '0;
        w_state_next     = S_SETTLE;
      end

      S_SETTLE: begin
        if (w_guard_last) begin
          w_clk_en_next   = 1'b1;
          w_cfg_done_next = r_from_req;
          w_from_req_next = 1'b0;
          w_state_next    = S_IDLE;
        end else begin
          w_guard_next = r_guard + C_GUARD_ONE;
        end
      end

      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_n < C_N_MIN) begin
            w_cfg_err_next = 1'b1;
          end else if (bus.req_n == r_div_n) begin
            w_cfg_done_next = 1'b1;
          end else begin
            w_pending_next  = bus.req_n;
            w_from_req_next = 1'b1;
            w_state_next    = S_WAIT_EDGE;
          end
        end
      end

      // Acceptance happens in IDLE, so a boundary seen at that edge is skipped.
      S_WAIT_EDGE: begin
        if (w_at_boundary) begin
          w_clk_en_next = 1'b0;
          w_guard_next  = '0;
          w_state_next  = S_GATE;
        end
      end

      S_GATE: begin
        if (w_guard_last) begin
          w_div_rst_n_next = 1'b0;
          w_div_n_next     = r_pending;
          w_state_next     = S_RELOAD;
        end else begin
          w_guard_next = r_guard + C_GUARD_ONE;
        end
      end

      default: begin
        w_state_next = S_RELOAD;
      end
    endcase
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.div_n     = r_div_n;
  assign bus.div_rst_n = r_div_rst_n;
  assign bus.clk_en    = r_clk_en;
  assign bus.cfg_done  = r_cfg_done;
  assign bus.cfg_err   = r_cfg_err;

endmodule

// File: doc/clk_div_reconfig_ctrl.md
# clk_div_reconfig_ctrl

- Run-time controller that reconfigures the team's integer clock divider (odd or even N, 50% duty) without glitches on the divided clock.
- Accepts new divide ratios over a valid/ready handshake and tracks the divider's phase with a mirror counter.
- At a period boundary it gates the divided clock, resets and reloads the divider, then re-enables it.
- Sits between the CSR/config logic and the divider instance plus its downstream clock gate, all on `clk_in`.

## Interface
- `N_W`, 8: width of divide-ratio fields.
- `N_DEFAULT`, 5: divide ratio loaded at reset; must be >= `N_MIN`.
- `N_MIN`, 2: smallest legal ratio.
- `GUARD_CYC`, 2: guard cycles before reload and after release; >= 1.
- `clk_in` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: new ratio request.
- `req_n` input N_W: requested ratio.
- `req_ready` output 1: high only in IDLE.
- `div_n` output N_W: ratio driven to the divider.
- `div_rst_n` output 1: synchronous reset to the divider, active-low.
- `clk_en` output 1: enable for the divided-clock gate.
- `busy` output 1: high in any state other than IDLE.
- `cfg_done` output 1: one-cycle pulse when a request completes.
- `cfg_err` output 1: one-cycle pulse when a request is rejected.

## Operation
**States:** RELOAD, SETTLE, IDLE, WAIT_EDGE, GATE.

**Reset (async):**
- State RELOAD, `div_n`=N_DEFAULT, `div_rst_n`=0, `clk_en`=0.
- `req_ready`=0, `busy`=1, `cfg_done`=0, `cfg_err`=0.
- `phase`=0, guard counter=0, pending ratio=N_DEFAULT.

**Phase mirror:**
- `phase` is held at 0 while `div_rst_n`=0.
- Otherwise it increments each edge and wraps from `div_n`-1 to 0, matching the divider's counter.

**State transitions:**
- **RELOAD:**
  - Next edge: `div_rst_n`<=1, guard counter<=0, go to SETTLE.
- **SETTLE:**
  - Counts GUARD_CYC edges.
  - On the last one: `clk_en`<=1, go to IDLE.
  - `cfg_done`<=1 only if entered from a request; not after reset.
- **IDLE:** `req_ready`=1. On an edge with `req_valid`=1:
  - `req_n` < N_MIN: `cfg_err` pulses, state stays IDLE, no output change.
  - `req_n` == `div_n`: `cfg_done` pulses, state stays IDLE, no reconfiguration.
  - Otherwise: pending<=`req_n`, go to WAIT_EDGE.
- **WAIT_EDGE:**
  - On the first edge where `phase`==`div_n`-1 is sampled: `clk_en`<=0, guard counter<=0, go to GATE.
  - If the request was accepted while `phase`==`div_n`-1, the controller waits a full period for the next occurrence.
- **GATE:**
  - Counts GUARD_CYC edges using the old `div_n`.
  - On the last one: `div_rst_n`<=0, `div_n`<=pending, go to RELOAD.

**Arithmetic and handshake rules:**
- Ratios are unsigned, N_W bits; every value from N_MIN to 2^N_W-1 is legal.
- Comparisons are full width with no truncation.
- `req_valid` outside IDLE is ignored, since `req_ready`=0; no queuing.
- Asserting `rst_n` mid-sequence discards the pending ratio immediately and restarts from the reset state.
- `cfg_done` and `cfg_err` are never high in the same cycle.

## Timing
- All outputs are registered, except `req_ready` and `busy`, which decode state directly.
- **Reset release:**
  - First edge E1 with `rst_n`=1: `div_rst_n` rises.
  - `clk_en` and `req_ready` rise at E1+GUARD_CYC.
- **Reconfiguration latency:**
  - Acceptance at edge T0; `clk_en` falls at edge Tk, the boundary edge (k >= 1).
  - `div_rst_n` is low and `div_n` updates at Tk+GUARD_CYC.
  - `div_rst_n` rises at Tk+GUARD_CYC+1.
  - `clk_en` rises and `cfg_done` pulses at Tk+2·GUARD_CYC+1.
  - `clk_en` is low for exactly 2·GUARD_CYC+1 cycles.
- **Reject/no-op path:** `cfg_err` or `cfg_done` is high in the cycle after acceptance; `req_ready` stays 1.
- **Gating point:** `clk_en` falls only at the edge that ends a divider period (`phase` wraps to 0). `clk_en` rises GUARD_CYC cycles after `div_rst_n` rises.

## Test plan
1. **Reset release.** Defaults N_DEFAULT=5, GUARD_CYC=2; release reset.
   - `div_rst_n`=1 after E1; `clk_en`=1 and `req_ready`=1 after E3.
   - `div_n`=5; no `cfg_done` pulse.
2. **Normal reconfiguration.** Accept `req_n`=7 at T0 with `phase`=1.
   - `clk_en` falls at T3.
   - `div_rst_n` is low for one cycle at T5, and `div_n`=7 from T5.
   - `clk_en` rises and `cfg_done` pulses at T8.
   - `phase` then wraps at 6.
3. **Boundary acceptance.** Accept `req_n`=4 at T0 with `phase`=4 (`div_n`=5).
   - `clk_en` falls at T5, not T0 or T1.
4. **Illegal and no-op requests.**
   - `req_n`=1: `cfg_err` pulses one cycle; `div_n` stays 5; `clk_en` never drops.
   - `req_n`=5: `cfg_done` pulses; no gating.
5. **Requests while busy.** Hold `req_valid` with `req_n`=9 throughout a 5→7 sequence.
   - Not accepted until IDLE.
   - Then a second full sequence runs, ending with `div_n`=9.
6. **Reset mid-sequence.** Assert `rst_n` during GATE.
   - All outputs immediately return to reset values, `div_n`=5.
   - The pending 7 is never applied.
